mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage access controller. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store control from EX/MEM into synchronous data-memory (DMEM) accesses or handshaked MMIO accesses, and asserts a pipeline stall while an access is outstanding. It produces the aligned, sign-extended load word `mem_data` and the MMIO read word `io_din`. The MEM/WB register selects between them using address bit 10.

Parameters:
- DMEM_AW, 8, DMEM word-address width.
- IO_SEL_BIT, 10, address bit that selects the MMIO region (1 = IO).
- IO_TIMEOUT, 255, maximum cycles in IO_WAIT before the access is abandoned.
- IO_CNT_W, 8, width of the timeout counter; IO_TIMEOUT must be < 2**IO_CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  EX/MEM slot holds a live instruction
- mem_read  in  1  load
- mem_write  in  1  store
- funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- dmem_addr  out  DMEM_AW  word address, addr[DMEM_AW+1:2]
- dmem_we  out  1  DMEM write strobe
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  DMEM read data, valid one cycle after the address
- io_req  out  1  MMIO request, held until io_ack
- io_we  out  1  MMIO write
- io_addr  out  8  addr[7:0], registered at issue
- io_wdata  out  32  registered at issue
- io_ack  in  1  MMIO completion
- io_rdata  in  32  MMIO read data, valid with io_ack
- stall  out  1  freezes PC/IF/ID/EX/EX-MEM
- mem_data  out  32  aligned, extended DMEM load result
- io_din  out  32  registered MMIO read result
- misalign  out  1  misaligned DMEM access in this cycle
- io_timeout  out  1  one-cycle pulse when IO_WAIT expires

Behaviour:
- Reset: state=IDLE; io_req, io_we, io_timeout, counter = 0; io_addr, io_wdata, io_din = 0.
- FSM states: IDLE, DMEM_RD, IO_WAIT, DONE.
- Region decode: io = addr[IO_SEL_BIT].
- IDLE, no access (!in_valid or neither read nor write): stall=0, no strobes.
- IDLE, DMEM store, aligned:
  - dmem_we=1 in the same cycle, stall=0, stay IDLE.
  - SB: be = 4'b0001<<addr[1:0], wdata[7:0] replicated ×4.
  - SH: be = 4'b0011<<addr[1:0], wdata[15:0] replicated ×2.
  - SW: be = 4'hF.
- IDLE, DMEM load, aligned:
  - Drive dmem_addr; stall=1; go to DMEM_RD.
  - Register addr[1:0] and funct3.
- DMEM_RD:
  - stall=0.
  - mem_data = lane-extracted dmem_rdata, sign- or zero-extended per the registered funct3; combinational, stable this cycle for MEM/WB capture.
  - Next state IDLE. Load latency is 2 cycles (1 stall).
- Misalignment (DMEM only): LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - misalign=1 combinationally; no strobe, no stall; mem_data=0.
- IDLE, IO access (any size; word semantics, no alignment check):
  - Register io_addr, io_wdata, io_we=mem_write; set io_req=1 next cycle.
  - stall=1; counter=0; go to IO_WAIT.
- IO_WAIT:
  - stall=1; io_req=1; counter increments each cycle.
  - On io_ack: io_din<=io_rdata (for reads), io_req<=0, go to DONE.
  - Else if counter==IO_TIMEOUT: io_din<=0, io_timeout pulse, io_req<=0, go to DONE.
  - io_ack and expiry in the same cycle: ack wins, no timeout pulse.
- DONE: stall=0; io_din stable; next state IDLE. The held instruction advances exactly once.
- Never re-triggering: DMEM_RD and DONE always return to IDLE, so the next access is decoded from the following instruction.
- in_valid drop in IO_WAIT: ignored. An issued MMIO request always completes (side effects).
- rst during IO_WAIT: next edge forces IDLE and io_req=0; the pending access is abandoned.
- mem_data when not in DMEM_RD: 0.
- io_din holds its last value until the next IO completion.

Decomposition:
- Package riscv_mem_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101 (stores reuse 000/001/010).
  - FSM state encoding.
  - IO_SEL_BIT default.
- Sub-module mem_load_align: combinational lane select plus sign/zero extension, driven by (rdata, off[1:0], funct3).

Test Plan:
- SW addr=0x20, wdata=0xA1B2C3D4, then LW 0x20 → dmem_be=F on the store cycle; load stalls exactly 1 cycle; mem_data=0xA1B2C3D4 in DMEM_RD.
- SB addr=0x23, wdata=0x80 → be=4'b1000, dmem_wdata=0x80808080. Then LB 0x23 → mem_data=0xFFFFFF80; LBU 0x23 → 0x00000080.
- LH addr=0x21 → misalign=1, dmem_we=0, stall=0, mem_data=0. LW addr=0x22 → misalign=1.
- IO read addr=0x400, io_ack after 3 cycles with io_rdata=0x5A → stall high 4 cycles; io_din=0x5A in DONE; stall=0 for exactly one cycle, then IDLE.
- IO read with no io_ack, IO_TIMEOUT=4 → io_timeout pulse once; io_din=0; io_req drops; DONE next. Separately, io_ack on the expiry cycle → no pulse, io_din=io_rdata.
- IO write in IO_WAIT, rst asserted → next cycle state=IDLE, io_req=0, stall=0. The following DMEM load behaves normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 codes, FSM
// encoding, the default MMIO select bit and store-side lane helpers.
package riscv_mem_pkg;

  // Load encodings; stores reuse the low three codes for SB/SH/SW.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int IO_SEL_BIT_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DMEM_RD = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } mau_state_e;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  // Byte enables for an aligned store at byte offset off.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across all lanes so any byte enable picks it up.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// DMEM and MMIO bus bundle seen by the MEM-stage access unit.
interface mem_access_unit_if #(
  parameter int DMEM_AW = 8
);
  logic [DMEM_AW-1:0] dmem_addr;
  logic               dmem_we;
  logic [3:0]         dmem_be;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic               io_req;
  logic               io_we;
  logic [7:0]         io_addr;
  logic [31:0]        io_wdata;
  logic               io_ack;
  logic [31:0]        io_rdata;

  modport master (
    output dmem_addr, dmem_we, dmem_be, dmem_wdata,
    input  dmem_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_ack, io_rdata
  );

  modport slave (
    input  dmem_addr, dmem_we, dmem_be, dmem_wdata,
    output dmem_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_ack, io_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load lane select plus sign/zero extension of a DMEM read word.
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_s = 8'h00;
    case (off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane according to the load kind.
  always_comb begin
    data = 32'h0000_0000;
    case (funct3)
      F3_LB:   data = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data = {24'h00_0000, byte_s};
      F3_LH:   data = {{16{half_s[15]}}, half_s};
      F3_LHU:  data = {16'h0000, half_s};
      F3_LW:   data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: issues DMEM stores/loads and handshaked
// MMIO accesses, stalling the pipeline while an access is outstanding.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int DMEM_AW    = 8,
  parameter int IO_SEL_BIT = IO_SEL_BIT_DEF,
  parameter int IO_TIMEOUT = 255,
  parameter int IO_CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  mem_access_unit_if.master   bus,
  output logic                stall,
  output logic [31:0]         mem_data,
  output logic [31:0]         io_din,
  output logic                misalign,
  output logic                io_timeout
);

  localparam logic [IO_CNT_W-1:0] TIMEOUT_C = IO_CNT_W'(IO_TIMEOUT);
  localparam logic [IO_CNT_W-1:0] CNT_ONE_C = IO_CNT_W'(1);

  mau_state_e          state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic [IO_CNT_W-1:0] cnt_q, cnt_d;
  logic                io_req_q, io_req_d;
  logic                io_we_q, io_we_d;
  logic [7:0]          io_addr_q, io_addr_d;
  logic [31:0]         io_wdata_q, io_wdata_d;
  logic [31:0]         io_din_q, io_din_d;
  logic                io_timeout_q, io_timeout_d;

  logic        access_s;
  logic        is_io_s;
  logic        mis_s;
  logic        stall_s;
  logic        misalign_s;
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] align_s;
  logic        unused_s;

  assign access_s = in_valid & (mem_read | mem_write);
  assign is_io_s  = addr[IO_SEL_BIT];
  assign mis_s    = is_misaligned(funct3, addr[1:0]);
  assign unused_s = ^addr;

  mem_load_align u_align (
    .rdata  (bus.dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (align_s)
  );

  // Next-state, strobe and stall decode for the access FSM.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    f3_d         = f3_q;
    cnt_d        = cnt_q;
    io_req_d     = io_req_q;
    io_we_d      = io_we_q;
    io_addr_d    = io_addr_q;
    io_wdata_d   = io_wdata_q;
    io_din_d     = io_din_q;
    io_timeout_d = 1'b0;
    stall_s      = 1'b0;
    misalign_s   = 1'b0;
    we_s         = 1'b0;
    be_s         = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (!access_s) begin
          state_d = ST_IDLE;
        end else if (is_io_s) begin
          io_addr_d  = addr[7:0];
          io_wdata_d = wdata;
          io_we_d    = mem_write;
          io_req_d   = 1'b1;
          cnt_d      = {IO_CNT_W{1'b0}};
          stall_s    = 1'b1;
          state_d    = ST_IO_WAIT;
        end else if (mis_s) begin
          misalign_s = 1'b1;
        end else if (mem_write) begin
          we_s = 1'b1;
          be_s = store_be(funct3, addr[1:0]);
        end else begin
          stall_s = 1'b1;
          off_d   = addr[1:0];
          f3_d    = funct3;
          state_d = ST_DMEM_RD;
        end
      end
      ST_DMEM_RD: begin
        state_d = ST_IDLE;
      end
      ST_IO_WAIT: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q + CNT_ONE_C;
        // An ack on the expiry cycle still completes the access normally.
        if (bus.io_ack) begin
          if (!io_we_q) begin
            io_din_d = bus.io_rdata;
          end else begin
            io_din_d = io_din_q;
          end
          io_req_d = 1'b0;
          state_d  = ST_DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          io_din_d     = 32'h0000_0000;
          io_timeout_d = 1'b1;
          io_req_d     = 1'b0;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_IO_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load result is only meaningful while the read data is on the bus.
  always_comb begin
    if (state_q == ST_DMEM_RD) begin
      mem_data = align_s;
    end else begin
      mem_data = 32'h0000_0000;
    end
  end

  // FSM and MMIO holding registers; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      cnt_q        <= {IO_CNT_W{1'b0}};
      io_req_q     <= 1'b0;
      io_we_q      <= 1'b0;
      io_addr_q    <= 8'h00;
      io_wdata_q   <= 32'h0000_0000;
      io_din_q     <= 32'h0000_0000;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      cnt_q        <= cnt_d;
      io_req_q     <= io_req_d;
      io_we_q      <= io_we_d;
      io_addr_q    <= io_addr_d;
      io_wdata_q   <= io_wdata_d;
      io_din_q     <= io_din_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  assign bus.dmem_addr  = addr[DMEM_AW+1:2];
  assign bus.dmem_we    = we_s;
  assign bus.dmem_be    = be_s;
  assign bus.dmem_wdata = store_data(funct3, wdata);
  assign bus.io_req     = io_req_q;
  assign bus.io_we      = io_we_q;
  assign bus.io_addr    = io_addr_q;
  assign bus.io_wdata   = io_wdata_q;
  assign stall          = stall_s;
  assign misalign       = misalign_s;
  assign io_din         = io_din_q;
  assign io_timeout     = io_timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a DMEM model, a scripted
// MMIO responder and a scoreboard of expected load / MMIO results.
module tb_mem_access_unit;
  import riscv_mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, misalign, io_timeout;
  logic [31:0] mem_data, io_din;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] dmem [0:255];

  mem_access_unit_if #(.DMEM_AW(8)) bus_if ();

  mem_access_unit #(.DMEM_AW(8), .IO_SEL_BIT(10), .IO_TIMEOUT(TO), .IO_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .bus        (bus_if),
    .stall      (stall),
    .mem_data   (mem_data),
    .io_din     (io_din),
    .misalign   (misalign),
    .io_timeout (io_timeout)
  );

  always #5 clk = ~clk;

  // Synchronous DMEM: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    bus_if.dmem_rdata <= dmem[bus_if.dmem_addr];
    if (bus_if.dmem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_if.dmem_be[b]) dmem[bus_if.dmem_addr][8*b +: 8] <= bus_if.dmem_wdata[8*b +: 8];
      end
    end
  end

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    in_valid = v; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus_if.io_ack = 1'b0; bus_if.io_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({stall, bus_if.io_req, bus_if.io_we, io_timeout, misalign} !== 5'b00000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 00000", {stall, bus_if.io_req, bus_if.io_we, io_timeout, misalign});
    end
    n_cmp++;
    if ({bus_if.io_addr, bus_if.io_wdata, io_din, mem_data} !== 104'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", bus_if.io_addr, bus_if.io_wdata, io_din, mem_data);
    end
    rst = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, F3_LW, 32'h20, 32'h0);
    #1;
    n_cmp++;
    if ({stall, bus_if.dmem_we} !== 2'b00) begin
      n_err++; $display("FAIL invalid_slot: got stall/we=%b expected 00", {stall, bus_if.dmem_we});
    end
  endtask

  task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, f3, a, wd);
    #1;
    n_cmp++;
    if ({bus_if.dmem_we, stall, misalign} !== 3'b100 || bus_if.dmem_be !== exp_be) begin
      n_err++; $display("FAIL %s_strobe: got we/stall/mis=%b be=%b expected 100 be=%b",
                        nm, {bus_if.dmem_we, stall, misalign}, bus_if.dmem_be, exp_be);
    end
    n_cmp++;
    if (bus_if.dmem_wdata !== exp_wd || bus_if.dmem_addr !== a[9:2]) begin
      n_err++; $display("FAIL %s_data: got %h @%h expected %h @%h", nm, bus_if.dmem_wdata, bus_if.dmem_addr, exp_wd, a[9:2]);
    end
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
    sb_q.push_back(exp);
    #1;
    n_cmp++;
    if ({stall, misalign, bus_if.dmem_we} !== 3'b100 || bus_if.dmem_addr !== a[9:2]) begin
      n_err++; $display("FAIL %s_issue: got stall/mis/we=%b addr=%h expected 100 addr=%h",
                        nm, {stall, misalign, bus_if.dmem_we}, bus_if.dmem_addr, a[9:2]);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL %s_rd_stall: got %b expected 0", nm, stall);
    end
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL %s_sb: got empty scoreboard expected entry", nm);
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (mem_data !== e) begin
        n_err++; $display("FAIL %s_data: got %h expected %h", nm, mem_data, e);
      end
    end
  endtask

  task automatic do_misalign(input string nm, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    drive(1'b1, !wr, wr, f3, a, 32'hFFFF_FFFF);
    #1;
    n_cmp++;
    if ({misalign, bus_if.dmem_we, stall} !== 3'b100 || mem_data !== 32'h0) begin
      n_err++; $display("FAIL %s: got mis/we/stall=%b data=%h expected 100 data=0", nm, {misalign, bus_if.dmem_we, stall}, mem_data);
    end
  endtask

  // ack_at: IO_WAIT cycle (1-based) on which io_ack is raised, 0 = never.
  task automatic io_access(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd, input logic exp_to,
                           input logic [31:0] exp_din, input int exp_stalls);
    int          stalls;
    logic        done;
    logic [31:0] e;
    stalls = 1; done = 1'b0;
    @(negedge clk);
    drive(1'b1, !wr, wr, F3_LW, a, wd);
    bus_if.io_ack = 1'b0;
    sb_q.push_back(exp_din);
    #1;
    n_cmp++;
    if ({stall, bus_if.io_req, bus_if.dmem_we} !== 3'b100) begin
      n_err++; $display("FAIL %s_issue: got stall/req/we=%b expected 100", nm, {stall, bus_if.io_req, bus_if.dmem_we});
    end
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      bus_if.io_ack   = (ack_at != 0 && k == ack_at);
      bus_if.io_rdata = bus_if.io_ack ? rd : 32'hDEAD_BEEF;
      #1;
      if (stall === 1'b1) begin
        stalls++;
        n_cmp++;
        if ({bus_if.io_req, bus_if.io_we, bus_if.io_addr, bus_if.io_wdata, io_timeout} !== {1'b1, wr, a[7:0], wd, 1'b0}) begin
          n_err++; $display("FAIL %s_wait%0d: got req/we/addr/wdata/to=%b/%b/%h/%h/%b expected 1/%b/%h/%h/0",
                            nm, k, bus_if.io_req, bus_if.io_we, bus_if.io_addr, bus_if.io_wdata, io_timeout, wr, a[7:0], wd);
        end
      end else begin
        done = 1'b1;
        bus_if.io_ack = 1'b0;
        n_cmp++;
        if (stalls !== exp_stalls || io_timeout !== exp_to || bus_if.io_req !== 1'b0) begin
          n_err++; $display("FAIL %s_done: got stalls=%0d to=%b req=%b expected stalls=%0d to=%b req=0",
                            nm, stalls, io_timeout, bus_if.io_req, exp_stalls, exp_to);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (io_din !== e) begin
          n_err++; $display("FAIL %s_din: got %h expected %h", nm, io_din, e);
        end
      end
    end
    if (!done) begin
      n_cmp++; n_err++; $display("FAIL %s_bound: got no completion expected DONE within 40 cycles", nm);
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    n_cmp++;
    if ({stall, io_timeout, bus_if.io_req} !== 3'b000 || io_din !== exp_din) begin
      n_err++; $display("FAIL %s_after: got stall/to/req=%b din=%h expected 000 din=%h",
                        nm, {stall, io_timeout, bus_if.io_req}, io_din, exp_din);
    end
  endtask

  task automatic test_word();
    do_store("sw20", F3_SW, 32'h20, 32'hA1B2_C3D4, 4'b1111, 32'hA1B2_C3D4);
    do_load("lw20", F3_LW, 32'h20, 32'hA1B2_C3D4);
  endtask

  task automatic test_byte_half();
    do_store("sb23", F3_SB, 32'h23, 32'h0000_0080, 4'b1000, 32'h8080_8080);
    do_load("lb23", F3_LB, 32'h23, 32'hFFFF_FF80);
    do_load("lbu23", F3_LBU, 32'h23, 32'h0000_0080);
    do_load("lb21", F3_LB, 32'h21, 32'hFFFF_FFC3);
    do_load("lh22", F3_LH, 32'h22, 32'hFFFF_80B2);
    do_load("lhu20", F3_LHU, 32'h20, 32'h0000_C3D4);
  endtask

  task automatic test_back_to_back();
    do_store("sh26", F3_SH, 32'h26, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
    do_load("lw24", F3_LW, 32'h24, 32'h1234_0000);
    do_store("sb25", F3_SB, 32'h25, 32'h0000_007F, 4'b0010, 32'h7F7F_7F7F);
    do_load("lh26", F3_LH, 32'h26, 32'h0000_1234);
    do_load("lb25", F3_LB, 32'h25, 32'h0000_007F);
  endtask

  task automatic test_misalign();
    do_misalign("mis_lh21", 1'b0, F3_LH, 32'h21);
    do_misalign("mis_lw22", 1'b0, F3_LW, 32'h22);
    do_misalign("mis_sw22", 1'b1, F3_SW, 32'h22);
    do_misalign("mis_lhu23", 1'b0, F3_LHU, 32'h23);
    do_load("lw20_after_mis", F3_LW, 32'h20, 32'h80B2_C3D4);
  endtask

  task automatic test_io();
    io_access("io_rd", 1'b0, 32'h400, 32'h0, 3, 32'h0000_005A, 1'b0, 32'h0000_005A, 4);
    io_access("io_to", 1'b0, 32'h404, 32'h0, 0, 32'h0, 1'b1, 32'h0, TO + 2);
    io_access("io_ackexp", 1'b0, 32'h408, 32'h0, TO + 1, 32'h1234_5678, 1'b0, 32'h1234_5678, TO + 2);
    io_access("io_wr", 1'b1, 32'h4F0, 32'hCAFE_F00D, 1, 32'h0BAD_0BAD, 1'b0, 32'h1234_5678, 2);
  endtask

  task automatic test_io_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, F3_SW, 32'h400, 32'h1111_2222);
    bus_if.io_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    n_cmp++;
    if ({stall, bus_if.io_req, io_timeout} !== 3'b000 || io_din !== 32'h0) begin
      n_err++; $display("FAIL io_rst: got stall/req/to=%b din=%h expected 000 din=0", {stall, bus_if.io_req, io_timeout}, io_din);
    end
    do_load("lw20_after_rst", F3_LW, 32'h20, 32'h80B2_C3D4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    bus_if.dmem_rdata = 32'h0;
    test_reset();
    test_word();
    test_byte_half();
    test_back_to_back();
    test_misalign();
    test_io();
    test_io_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
